pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port EX_stall, input, 1 bit: load-use stall request from the EX hazard checker.
REQ-004 SHALL have port EX_branch_taken, input, 1 bit: resolved taken branch or jump in EX.
REQ-005 SHALL have port EX_branch_target, input, 32 bits: redirect address for the EX branch.
REQ-006 SHALL have port MEM_busy, input, 1 bit: data memory not ready; freezes the whole pipe.
REQ-007 SHALL have port PC_write_enable, output, 1 bit: PC may advance.
REQ-008 SHALL have ports PC_redirect_enable (output, 1 bit) and PC_redirect_target (output, 32 bits): load target into PC.
REQ-009 SHALL have ports IF_ID_hold and IF_ID_flush, outputs, 1 bit each: hold or zero IF_ID_reg.
REQ-010 SHALL have ports ID_EX_hold and ID_EX_bubble, outputs, 1 bit each: hold or insert NOP into ID_EX_reg.
REQ-011 SHALL have ports EX_MEM_hold and EX_MEM_bubble, outputs, 1 bit each.
REQ-012 SHALL have port MEM_WB_hold, output, 1 bit.
REQ-013 SHALL have ports stall_cycles and flush_count, outputs, 32 bits each: performance counters.

Function
REQ-014 SHALL hold state in a registered FSM with states RUN, LOAD_STALL and FLUSH; all stage controls SHALL be combinational from state plus current inputs (same-cycle response).
REQ-015 SHALL use priority, highest first: MEM_busy, then EX_stall, then EX_branch_taken.
REQ-016 SHALL, when MEM_busy=1 in any state: assert all *_hold outputs; deassert PC_write_enable, every bubble, flush and redirect; keep state unchanged.
REQ-017 SHALL, in RUN with EX_stall=1: set PC_write_enable=0, IF_ID_hold=1, ID_EX_hold=1, EX_MEM_bubble=1; go to LOAD_STALL.
REQ-018 SHALL, in LOAD_STALL, ignore EX_stall for that cycle (maximum load-use stall is one cycle) and return to RUN, unless MEM_busy applies.
REQ-019 SHALL, with EX_branch_taken=1 in RUN or LOAD_STALL and no higher-priority condition:
- assert PC_redirect_enable with PC_redirect_target=EX_branch_target;
- assert IF_ID_flush and ID_EX_bubble;
- go to FLUSH.
REQ-020 SHALL, in FLUSH, ignore EX_branch_taken and EX_stall (EX holds a bubble), drive normal flow, and return to RUN.
REQ-021 SHALL, with EX_stall and EX_branch_taken asserted together, stall only; the branch re-resolves on the next cycle.
REQ-022 SHALL drive normal flow when no condition is active: PC_write_enable=1 and every other control 0.
REQ-023 SHALL drive PC_redirect_target=0 whenever PC_redirect_enable=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter RUN and clear both counters.
REQ-025 SHALL, while rst=1, drive PC_write_enable=0, IF_ID_flush=1, ID_EX_bubble=1, EX_MEM_bubble=1 and all other controls 0, overriding every input.
REQ-026 SHALL, when rst asserts during LOAD_STALL or FLUSH, abandon that state with no residual hold or flush after reset is released.

Configuration
REQ-027 SHALL, with macro PIPE_PERF_COUNTERS_EN defined:
- increment stall_cycles on each cycle with EX_stall-induced or MEM_busy hold;
- increment flush_count on each redirect;
- saturate both at 32'hFFFF_FFFF.
REQ-028 SHALL, without PIPE_PERF_COUNTERS_EN, keep both ports present, tie them to 0, and instantiate no counter logic.

Structure
REQ-029 SHALL take these from shared package pipeline_pkg: the FSM state typedef (RUN, LOAD_STALL, FLUSH), XLEN=32, and the opcode constants shared with the hazard checkers.
REQ-030 SHALL implement the counters as one sub-module, pipe_event_counter (enable, saturating, synchronous clear), instantiated twice.

Verification
REQ-031 Load-use: one-cycle EX_stall pulse in RUN -> that cycle PC_write_enable=0, IF_ID_hold=1, ID_EX_hold=1, EX_MEM_bubble=1; next cycle normal; stall_cycles=1.
REQ-032 Held stall: EX_stall high 3 cycles -> stall asserted cycles 1 and 3, normal flow cycle 2.
REQ-033 Branch: EX_branch_taken=1, target 32'h0000_0040 -> same cycle redirect to 0x40 with IF_ID_flush and ID_EX_bubble; next-cycle EX_branch_taken ignored; flush_count=1.
REQ-034 Collision: EX_stall=1 and EX_branch_taken=1 together -> stall controls only, no redirect; branch next cycle -> redirect.
REQ-035 Memory freeze: MEM_busy high 4 cycles during FLUSH -> all holds asserted 4 cycles, state stays FLUSH, then one normal-flow cycle.
REQ-036 Reset mid-stall: rst in LOAD_STALL -> reset controls; after release, normal flow and counters 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : types and constants shared by the pipeline control blocks
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2
   } pipe_state_e;

   // Opcodes the hazard checkers decode to raise EX_stall / EX_branch_taken
   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;

endpackage

`default_nettype wire

// File: rtl/pipe_event_counter.sv
// ============================================================================
// pipe_event_counter : enabled, saturating event counter with synchronous clear
// Revision           : 1.0
// ============================================================================
`default_nettype none

module pipe_event_counter
   import pipeline_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != C_MAX)) begin
         count_d = count_q + C_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// pipeline_stall_controller : load-use stall / branch flush / memory freeze
// control for a 5-stage pipe. Counters built only with PIPE_PERF_COUNTERS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_controller
   import pipeline_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            EX_stall,
   input  logic            EX_branch_taken,
   input  logic [XLEN-1:0] EX_branch_target,
   input  logic            MEM_busy,
   output logic            PC_write_enable,
   output logic            PC_redirect_enable,
   output logic [XLEN-1:0] PC_redirect_target,
   output logic            IF_ID_hold,
   output logic            IF_ID_flush,
   output logic            ID_EX_hold,
   output logic            ID_EX_bubble,
   output logic            EX_MEM_hold,
   output logic            EX_MEM_bubble,
   output logic            MEM_WB_hold,
   output logic [XLEN-1:0] stall_cycles,
   output logic [XLEN-1:0] flush_count
);

   pipe_state_e state_q;
   pipe_state_e state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      PC_write_enable    = 1'b1;
      PC_redirect_enable = 1'b0;
      PC_redirect_target = '0;
      IF_ID_hold         = 1'b0;
      IF_ID_flush        = 1'b0;
      ID_EX_hold         = 1'b0;
      ID_EX_bubble       = 1'b0;
      EX_MEM_hold        = 1'b0;
      EX_MEM_bubble      = 1'b0;
      MEM_WB_hold        = 1'b0;

      if (rst) begin
         state_d         = RUN;
         PC_write_enable = 1'b0;
         IF_ID_flush     = 1'b1;
         ID_EX_bubble    = 1'b1;
         EX_MEM_bubble   = 1'b1;
      end else if (MEM_busy) begin
         PC_write_enable = 1'b0;
         IF_ID_hold      = 1'b1;
         ID_EX_hold      = 1'b1;
         EX_MEM_hold     = 1'b1;
         MEM_WB_hold     = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               // A stall wins over a simultaneous branch; the branch re-resolves next cycle
               if (EX_stall) begin
                  state_d         = LOAD_STALL;
                  PC_write_enable = 1'b0;
                  IF_ID_hold      = 1'b1;
                  ID_EX_hold      = 1'b1;
                  EX_MEM_bubble   = 1'b1;
               end else if (EX_branch_taken) begin
                  state_d            = FLUSH;
                  PC_redirect_enable = 1'b1;
                  PC_redirect_target = EX_branch_target;
                  IF_ID_flush        = 1'b1;
                  ID_EX_bubble       = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            LOAD_STALL: begin
               if (EX_branch_taken) begin
                  state_d            = FLUSH;
                  PC_redirect_enable = 1'b1;
                  PC_redirect_target = EX_branch_target;
                  IF_ID_flush        = 1'b1;
                  ID_EX_bubble       = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            FLUSH: begin
               state_d = RUN;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

`ifdef PIPE_PERF_COUNTERS_EN
   logic stall_evt;
   logic flush_evt;

   assign stall_evt = !rst && (MEM_busy || ((state_q == RUN) && EX_stall));
   assign flush_evt = PC_redirect_enable;

   pipe_event_counter #(.WIDTH(XLEN)) u_stall_ctr (
      .clk     (clk),
      .rst     (rst),
      .en_i    (stall_evt),
      .clr_i   (1'b0),
      .count_o (stall_cycles)
   );

   pipe_event_counter #(.WIDTH(XLEN)) u_flush_ctr (
      .clk     (clk),
      .rst     (rst),
      .en_i    (flush_evt),
      .clr_i   (1'b0),
      .count_o (flush_count)
   );
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// ============================================================================
// tb_pipeline_stall_controller : directed vector table plus randomized run
// against a behavioural model of the stall/flush rules.
// ============================================================================
`default_nettype none

module tb_pipeline_stall_controller;

   // Control bundle: {PCwe, redir, IFIDhold, IFIDflush, IDEXhold, IDEXbubble, EXMEMhold, EXMEMbubble, MEMWBhold}
   localparam logic [8:0] C_NORM   = 9'b1_0_0_0_0_0_0_0_0;
   localparam logic [8:0] C_RST    = 9'b0_0_0_1_0_1_0_1_0;
   localparam logic [8:0] C_STALL  = 9'b0_0_1_0_1_0_0_1_0;
   localparam logic [8:0] C_REDIR  = 9'b1_1_0_1_0_1_0_0_0;
   localparam logic [8:0] C_FREEZE = 9'b0_0_1_0_1_0_1_0_1;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic        busy;
      logic [31:0] tgt;
      logic [8:0]  exp_ctl;
      logic [31:0] exp_tgt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        EX_stall;
   logic        EX_branch_taken;
   logic [31:0] EX_branch_target;
   logic        MEM_busy;
   logic        PC_write_enable;
   logic        PC_redirect_enable;
   logic [31:0] PC_redirect_target;
   logic        IF_ID_hold;
   logic        IF_ID_flush;
   logic        ID_EX_hold;
   logic        ID_EX_bubble;
   logic        EX_MEM_hold;
   logic        EX_MEM_bubble;
   logic        MEM_WB_hold;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   int n_vec  = 0;
   int n_fail = 0;

   // Model state: what the previous advancing cycle did
   bit          m_prev_stall;
   bit          m_prev_redir;
   logic [31:0] m_stall_cnt;
   logic [31:0] m_flush_cnt;

   vec_t tbl[$];

   always #5 clk = ~clk;

   pipeline_stall_controller dut (
      .clk                (clk),
      .rst                (rst),
      .EX_stall           (EX_stall),
      .EX_branch_taken    (EX_branch_taken),
      .EX_branch_target   (EX_branch_target),
      .MEM_busy           (MEM_busy),
      .PC_write_enable    (PC_write_enable),
      .PC_redirect_enable (PC_redirect_enable),
      .PC_redirect_target (PC_redirect_target),
      .IF_ID_hold         (IF_ID_hold),
      .IF_ID_flush        (IF_ID_flush),
      .ID_EX_hold         (ID_EX_hold),
      .ID_EX_bubble       (ID_EX_bubble),
      .EX_MEM_hold        (EX_MEM_hold),
      .EX_MEM_bubble      (EX_MEM_bubble),
      .MEM_WB_hold        (MEM_WB_hold),
      .stall_cycles       (stall_cycles),
      .flush_count        (flush_count)
   );

   function automatic logic [8:0] act_ctl();
      return {PC_write_enable, PC_redirect_enable, IF_ID_hold, IF_ID_flush,
              ID_EX_hold, ID_EX_bubble, EX_MEM_hold, EX_MEM_bubble, MEM_WB_hold};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural rules: reset > memory freeze > post-redirect cycle ignores EX
   // > load-use stall (at most one cycle) > taken branch > normal flow.
   task automatic model_eval(input logic r, input logic s, input logic b, input logic m,
                             input logic [31:0] t, output logic [8:0] ctl,
                             output logic [31:0] tg);
      tg = 32'h0;
      if (r)                         ctl = C_RST;
      else if (m)                    ctl = C_FREEZE;
      else if (m_prev_redir)         ctl = C_NORM;
      else if (s && !m_prev_stall)   ctl = C_STALL;
      else if (b) begin              ctl = C_REDIR; tg = t; end
      else                           ctl = C_NORM;
   endtask

   task automatic model_advance(input logic r, input logic [8:0] ctl);
      if (r) begin
         m_prev_stall = 1'b0;
         m_prev_redir = 1'b0;
         m_stall_cnt  = 32'h0;
         m_flush_cnt  = 32'h0;
      end else begin
         if ((ctl == C_FREEZE || ctl == C_STALL) && m_stall_cnt != 32'hFFFF_FFFF)
            m_stall_cnt = m_stall_cnt + 32'd1;
         if (ctl == C_REDIR && m_flush_cnt != 32'hFFFF_FFFF)
            m_flush_cnt = m_flush_cnt + 32'd1;
         if (ctl != C_FREEZE) begin
            m_prev_stall = (ctl == C_STALL);
            m_prev_redir = (ctl == C_REDIR);
         end
      end
   endtask

   task automatic check_counters(input string tag);
`ifdef PIPE_PERF_COUNTERS_EN
      check({tag, ".stall_cycles"}, stall_cycles, m_stall_cnt);
      check({tag, ".flush_count"},  flush_count,  m_flush_cnt);
`else
      check({tag, ".stall_cycles"}, stall_cycles, 32'h0);
      check({tag, ".flush_count"},  flush_count,  32'h0);
`endif
   endtask

   task automatic drive(input logic r, input logic s, input logic b, input logic m,
                        input logic [31:0] t);
      @(posedge clk);
      #1;
      rst              = r;
      EX_stall         = s;
      EX_branch_taken  = b;
      MEM_busy         = m;
      EX_branch_target = t;
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic r, input logic s, input logic b, input logic m,
                               input logic [31:0] t, input logic [8:0] c,
                               input logic [31:0] et);
      vec_t v;
      v.rst = r; v.stall = s; v.br = b; v.busy = m; v.tgt = t;
      v.exp_ctl = c; v.exp_tgt = et;
      return v;
   endfunction

   initial begin
      logic [8:0]  mctl;
      logic [31:0] mtgt;

      rst = 1'b1; EX_stall = 1'b0; EX_branch_taken = 1'b0; MEM_busy = 1'b0;
      EX_branch_target = 32'h0;

      //               rst stall br busy target        expected   exp target
      tbl.push_back(mk(1, 0, 0, 0, 32'h0,         C_RST,    32'h0));
      tbl.push_back(mk(1, 1, 1, 1, 32'hDEAD_BEEF, C_RST,    32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 32'h0,         C_NORM,   32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 32'h0,         C_STALL,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 32'h0,         C_NORM,   32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 32'h0,         C_STALL,  32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 32'h0,         C_NORM,   32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 32'h0,         C_STALL,  32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 32'h0,         C_NORM,   32'h0));
      tbl.push_back(mk(0, 0, 1, 0, 32'h0000_0040, C_REDIR,  32'h0000_0040));
      tbl.push_back(mk(0, 0, 1, 0, 32'h0000_0080, C_NORM,   32'h0));
      tbl.push_back(mk(0, 1, 1, 0, 32'h0000_0044, C_STALL,  32'h0));
      tbl.push_back(mk(0, 0, 1, 0, 32'h0000_0044, C_REDIR,  32'h0000_0044));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 1, 1, 1, 32'h0000_0099, C_FREEZE, 32'h0));
      tbl.push_back(mk(0, 1, 1, 0, 32'h0000_0099, C_NORM,   32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 32'h0,         C_STALL,  32'h0));
      tbl.push_back(mk(1, 0, 0, 0, 32'h0,         C_RST,    32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 32'h0,         C_NORM,   32'h0));
      tbl.push_back(mk(0, 1, 0, 1, 32'h0,         C_FREEZE, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 32'h0,         C_NORM,   32'h0));

      // Bring the design out of its unknown power-up state before checking counters
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      model_advance(1'b1, C_RST);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].busy, tbl[i].tgt);
         check($sformatf("tbl%0d.ctl", i), {23'h0, act_ctl()}, {23'h0, tbl[i].exp_ctl});
         check($sformatf("tbl%0d.target", i), PC_redirect_target, tbl[i].exp_tgt);
         check_counters($sformatf("tbl%0d", i));
         model_advance(tbl[i].rst, tbl[i].exp_ctl);
      end

      // One more cycle so the counters reflect the final table row
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_counters("tbl_end");
      model_eval(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mctl, mtgt);
      model_advance(1'b0, mctl);

      for (int c = 0; c < 400; c++) begin
         logic        r, s, b, m;
         logic [31:0] t;
         r = ($urandom_range(0, 29) == 0);
         m = ($urandom_range(0, 4) == 0);
         s = ($urandom_range(0, 2) == 0);
         b = ($urandom_range(0, 2) == 0);
         t = $urandom;
         drive(r, s, b, m, t);
         model_eval(r, s, b, m, t, mctl, mtgt);
         check($sformatf("rnd%0d.ctl", c), {23'h0, act_ctl()}, {23'h0, mctl});
         check($sformatf("rnd%0d.target", c), PC_redirect_target, mtgt);
         check_counters($sformatf("rnd%0d", c));
         model_advance(r, mctl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
